mux8_rr_arbiter: RTL



---
 rtl/mux8_arb_pkg.sv | 17 +
 rtl/rr_pick8.sv | 34 +++
 rtl/mux8_rr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mux8_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mux8_arb_pkg : shared types and sizes for the 8-way round-robin mux. |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package mux8_arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// +----------------------------------------------------------------------+
// | rr_pick8 : combinational round-robin scan, first set req from ptr.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any_req
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | mux8_rr_arbiter : round-robin 8:1 mux sequencer, burst-bounded.      |
// | Optional stall timeout via macro MUX8_ARB_TIMEOUT_EN.                |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic                      data_ready,
    output logic                      data_valid,
    output logic [DATA_W-1:0]         data_out,
    output logic [SEL_W-1:0]          select,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      beat_ack
`ifdef MUX8_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       beat_cnt;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             release_req;
    logic             burst_done;
    logic             force_exit;

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign data_out    = data_in[select*DATA_W +: DATA_W];
    assign data_valid  = (state == GRANT) && req[select];
    assign beat_ack    = data_valid && data_ready;
    assign release_req = (state == GRANT) && !req[select];
    assign burst_done  = beat_ack && (beat_cnt == BURST_LAST);

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);
    logic [7:0] stall_cnt;

    assign timeout_err = data_valid && !data_ready && (stall_cnt == STALL_LAST);
    assign force_exit  = timeout_err;

    always_ff @(posedge clk) begin
        if (rst || state != GRANT || beat_ack || release_req || timeout_err) begin
            stall_cnt <= '0;
        end else if (data_valid) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`else
    // Stall limit is meaningless without the timeout feature.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign force_exit     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            select   <= '0;
            grant    <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        select   <= winner;
                        grant    <= NUM_REQ'(1) << winner;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_req || burst_done || force_exit) begin
                        grant    <= '0;
                        ptr      <= select + SEL_W'(1);
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (beat_ack) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
